// File: rtl/atanh_sched_rom.sv
// atanh_sched_rom: sequenced atanh-constant generator for the hyperbolic CORDIC datapath.
// Constants are encoded into a ROM at elaboration; beats leave through a registered valid/ready port.
module atanh_sched_rom #(
   parameter int EXP_SIZE      = 8,
   parameter int MANTISSA_SIZE = 7,
   parameter int NEG_ITERS     = 6,
   parameter int POS_ITERS     = 13,
   parameter int REPEAT_EN     = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              start,
   input  logic signed [7:0]                 start_index,
   input  logic signed [7:0]                 last_index,
   output logic                              busy,
   output logic                              err,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic signed [7:0]                 out_index,
   output logic [EXP_SIZE+MANTISSA_SIZE:0]   out_value,
   output logic                              out_repeat,
   output logic                              out_last
);

   localparam int W       = 1 + EXP_SIZE + MANTISSA_SIZE;
   localparam int DEPTH   = NEG_ITERS + POS_ITERS;
   localparam int BIAS    = (1 << (EXP_SIZE - 1)) - 1;
   localparam int EXP_MAX = (1 << EXP_SIZE) - 1;
   localparam logic signed [7:0] MIN_IDX = 8'(1 - NEG_ITERS);
   localparam logic signed [7:0] MAX_IDX = 8'(POS_ITERS);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, ERR = 2'd2} state_t;

   function automatic real atanh_of(input int k);
      real x;
      if (k <= 0) begin
         x = 1.0 - (2.0 ** $itor(k - 2));
      end else begin
         x = 2.0 ** $itor(-k);
      end
      return $atanh(x);
   endfunction

   // Positive real to sign|exp|mantissa, round-to-nearest-even, flush to +0 below min normal.
   function automatic logic [W-1:0] encode(input real x);
      real          m;
      real          scaled;
      real          rem;
      int           e;
      int           frac;
      int           be;
      logic [W-1:0] v;
      m = x;
      e = 0;
      v = {W{1'b0}};
      if (m > 0.0) begin
         for (int i = 0; (i < 400) && ((m >= 2.0) || (m < 1.0)); i++) begin
            if (m >= 2.0) begin
               m = m / 2.0;
               e = e + 1;
            end else begin
               m = m * 2.0;
               e = e - 1;
            end
         end
         scaled = (m - 1.0) * (2.0 ** $itor(MANTISSA_SIZE));
         frac   = $rtoi(scaled);
         rem    = scaled - $itor(frac);
         if ((rem > 0.5) || ((rem == 0.5) && (frac[0] == 1'b1))) begin
            frac = frac + 1;
         end
         if (frac == (1 << MANTISSA_SIZE)) begin
            frac = 0;
            e    = e + 1;
         end
         be = e + BIAS;
         if (be < 1) begin
            v = {W{1'b0}};
         end else if (be >= EXP_MAX) begin
            v = {1'b0, {EXP_SIZE{1'b1}}, {MANTISSA_SIZE{1'b0}}};
         end else begin
            v = {1'b0, be[EXP_SIZE-1:0], frac[MANTISSA_SIZE-1:0]};
         end
      end
      return v;
   endfunction

   function automatic logic is_repeat(input int k);
      int   r;
      logic hit;
      r   = 4;
      hit = 1'b0;
      for (int i = 0; (i < 32) && (r <= POS_ITERS); i++) begin
         hit = hit | (r == k);
         r   = 3 * r + 1;
      end
      return hit & (REPEAT_EN != 0);
   endfunction

   state_t               state_r, state_n_s;
   logic                 busy_r, err_r, valid_r, rep_r, last_r, need_rep_r;
   logic signed [7:0]    idx_r, lim_r;
   logic [W-1:0]         val_r;
   logic                 load_s, hs_s, range_ok_s;
   logic signed [7:0]    cand_idx_s, lim_s;
   logic                 cand_rep_s, cand_need_s, cand_last_s;
   logic [W-1:0]         cand_val_s;
   logic [W-1:0]         rom_val_s [DEPTH];
   logic                 rom_rep_s [DEPTH];
   logic signed [7:0]    rom_idx_s [DEPTH];

   for (genvar g = 0; g < DEPTH; g++) begin : g_rom
      localparam int                K   = g - (NEG_ITERS - 1);
      localparam logic [W-1:0]      VAL = encode(atanh_of(K));
      localparam logic              REP = is_repeat(K);
      localparam logic signed [7:0] KI  = 8'(K);
      assign rom_val_s[g] = VAL;
      assign rom_rep_s[g] = REP;
      assign rom_idx_s[g] = KI;
   end

   assign hs_s       = valid_r & out_ready;
   assign range_ok_s = (start_index <= last_index) && (start_index >= MIN_IDX) &&
                       (last_index <= MAX_IDX);

   // Next beat: first beat of a new range in IDLE, otherwise repeat copy or index+1.
   always_comb begin
      cand_idx_s = start_index;
      cand_rep_s = 1'b0;
      lim_s      = last_index;
      if (state_r == RUN) begin
         lim_s = lim_r;
         if (need_rep_r && !rep_r) begin
            cand_idx_s = idx_r;
            cand_rep_s = 1'b1;
         end else begin
            cand_idx_s = idx_r + 8'sd1;
            cand_rep_s = 1'b0;
         end
      end else begin
         lim_s      = last_index;
         cand_idx_s = start_index;
      end
   end

   // ROM read for the candidate index.
   always_comb begin
      cand_val_s  = {W{1'b0}};
      cand_need_s = 1'b0;
      for (int j = 0; j < DEPTH; j++) begin
         cand_val_s  = (rom_idx_s[j] == cand_idx_s) ? rom_val_s[j] : cand_val_s;
         cand_need_s = (rom_idx_s[j] == cand_idx_s) ? rom_rep_s[j] : cand_need_s;
      end
   end

   assign cand_last_s = (cand_idx_s == lim_s) && (cand_rep_s || !cand_need_s);

   // Next-state decode and beat-load strobe.
   always_comb begin
      state_n_s = state_r;
      load_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               if (range_ok_s) begin
                  state_n_s = RUN;
                  load_s    = 1'b1;
               end else begin
                  state_n_s = ERR;
               end
            end else begin
               state_n_s = IDLE;
            end
         end
         RUN: begin
            if (hs_s) begin
               if (last_r) begin
                  state_n_s = IDLE;
               end else begin
                  load_s = 1'b1;
               end
            end else begin
               state_n_s = RUN;
            end
         end
         ERR:     state_n_s = IDLE;
         default: state_n_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // Registered status and output beat; held while stalled.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy_r     <= 1'b0;
         err_r      <= 1'b0;
         valid_r    <= 1'b0;
         idx_r      <= 8'sd0;
         val_r      <= {W{1'b0}};
         rep_r      <= 1'b0;
         last_r     <= 1'b0;
         need_rep_r <= 1'b0;
         lim_r      <= 8'sd0;
      end else begin
         busy_r <= (state_n_s != IDLE);
         err_r  <= (state_n_s == ERR);
         if (load_s) begin
            valid_r    <= 1'b1;
            idx_r      <= cand_idx_s;
            val_r      <= cand_val_s;
            rep_r      <= cand_rep_s;
            last_r     <= cand_last_s;
            need_rep_r <= cand_need_s;
            lim_r      <= lim_s;
         end else if (hs_s) begin
            valid_r <= 1'b0;
         end else begin
            valid_r <= valid_r;
         end
      end
   end

   assign busy       = busy_r;
   assign err        = err_r;
   assign out_valid  = valid_r;
   assign out_index  = idx_r;
   assign out_value  = val_r;
   assign out_repeat = rep_r;
   assign out_last   = last_r;

endmodule
